uart_rx_fifo_ctrl: RTL

Parametrised receive-side buffer for the UART controller. It converts level-held `rx_ready` and `read` requests into single-cycle push/pop strobes and stores received words in an internal circular buffer. The buffer is inferred RAM, not vendor IP. It adds full/almost-full/occupancy status and sticky overflow/underflow error flags. It sits between the UART receiver and the host-side register/bus interface.

---
 rtl/uart_rx_fifo_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: receive-side word buffer between the UART receiver and the
// host register interface. Level-held rx_ready/read requests are edge-detected
// into one-cycle push/pop strobes that execute one edge later. Words are stored
// in an inferred circular RAM.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   rx_ready     receiver word-valid level (one push per rising level)
//   data         received word, latched when rx_ready rises
//   read         host pop request level (one pop per rising level)
//   clr_err      synchronous clear of the sticky error flags
//   data_out     last popped word, held until the next successful pop
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AF_LEVEL
//   count        occupancy, 0..DEPTH
//   overflow     sticky: push attempted while full
//   underflow    sticky: pop attempted while empty
module uart_rx_fifo_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] data,
  input  logic              read,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rx_q;
  logic              rd_q;
  logic              wr_stb;
  logic              rd_stb;
  logic [DATA_W-1:0] data_lat;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;

  logic              do_push_c;
  logic              do_pop_c;
  logic              push_rise_c;
  logic              pop_rise_c;

  // Status decodes of the registered occupancy.
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AF_CNT);

  assign push_rise_c = rx_ready & ~rx_q;
  assign pop_rise_c  = read & ~rd_q;

  // Full/empty are judged before the edge, so a same-cycle pop never frees
  // room for a push, and a same-cycle push is never popped.
  assign do_push_c = wr_stb & ~full;
  assign do_pop_c  = rd_stb & ~empty;

  // Request edge detect; strobes are one cycle wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q   <= 1'b0;
      rd_q   <= 1'b0;
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
    end else begin
      rx_q   <= rx_ready;
      rd_q   <= read;
      wr_stb <= push_rise_c;
      rd_stb <= pop_rise_c;
    end
  end

  // Word capture on the detecting edge; consumed by the push one edge later.
  always_ff @(posedge clk) begin
    if (push_rise_c) begin
      data_lat <= data;
    end
  end

  // Storage array, intentionally not reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && do_push_c) begin
      mem[wptr] <= data_lat;
    end
  end

  // Pointers, occupancy and popped data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (do_push_c) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (do_pop_c) begin
        data_out <= mem[rptr];
        rptr     <= rptr + ADDR_W'(1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error on the clearing edge keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_stb && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_stb && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
